// File: rtl/alarm_clock_ctrl.sv
// Alarm clock controller: time keeping with set handshake, plus an alarm FSM.
// Optional snooze support is enabled by defining the SNOOZE_EN macro.
module alarm_clock_ctrl #(
  parameter int unsigned RING_TIMEOUT_MIN = 10,
  parameter int unsigned SNOOZE_MIN       = 9
) (
  input  logic       clk256_i,
  input  logic       reset_ni,
  input  logic       one_second_i,
  input  logic       one_minute_i,
  input  logic       fast_req_i,
  output logic       fast_mode_o,
  input  logic       set_req_i,
  input  logic [4:0] set_hour_i,
  input  logic [5:0] set_min_i,
  output logic       set_ack_o,
  output logic       set_err_o,
  input  logic       alarm_set_i,
  input  logic       alarm_en_i,
  input  logic       alarm_off_i,
  input  logic       snooze_i,
  output logic [4:0] cur_hour_o,
  output logic [5:0] cur_min_o,
  output logic       alarm_active_o,
  output logic       colon_o
);

  typedef enum logic [1:0] {StRun, StLoad, StAck} time_st_e;
`ifdef SNOOZE_EN
  typedef enum logic [1:0] {StIdle, StArmed, StRing, StSnooze} alarm_st_e;
  localparam logic [6:0] SnoozeLim = 7'(SNOOZE_MIN);
`else
  typedef enum logic [1:0] {StIdle, StArmed, StRing} alarm_st_e;
  logic unused_snooze;
  assign unused_snooze = snooze_i;
`endif
  localparam logic [6:0] TimeoutLim = 7'(RING_TIMEOUT_MIN);

  time_st_e  time_q, time_d;
  alarm_st_e alarm_q, alarm_d;
  logic [4:0] hour_q, hour_d, al_hour_q, al_hour_d;
  logic [5:0] min_q, min_d, al_min_q, al_min_d;
  logic [5:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       fast_q, fast_d;
  logic       colon_q, colon_d;

  logic       set_valid;
  logic       inc;
  logic [4:0] inc_hour;
  logic [5:0] inc_min;
  logic [6:0] cnt_inc;

  assign set_valid = (set_hour_i <= 5'd23) && (set_min_i <= 6'd59);
  // Minute pulses arriving while a set is being loaded are dropped.
  assign inc       = one_minute_i && (time_q != StLoad);
  assign cnt_inc   = {1'b0, cnt_q} + 7'd1;

  always_comb begin
    inc_hour = hour_q;
    inc_min  = min_q + 6'd1;
    if (min_q == 6'd59) begin
      inc_min  = 6'd0;
      inc_hour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    end
  end

  always_comb begin
    time_d = time_q;
    hour_d = hour_q;
    min_d  = min_q;
    err_d  = err_q;
    if (inc) begin
      hour_d = inc_hour;
      min_d  = inc_min;
    end
    case (time_q)
      StRun: begin
        if (set_req_i) time_d = StLoad;
      end
      StLoad: begin
        if (set_valid) begin
          hour_d = set_hour_i;
          min_d  = set_min_i;
          err_d  = 1'b0;
        end else begin
          err_d  = 1'b1;
        end
        time_d = StAck;
      end
      StAck: begin
        if (!set_req_i) time_d = StRun;
      end
      default: time_d = StRun;
    endcase
    fast_d  = fast_req_i && (time_d == StRun);
    colon_d = colon_q ^ one_second_i;
  end

  always_comb begin
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    if (alarm_set_i && set_valid) begin
      al_hour_d = set_hour_i;
      al_min_d  = set_min_i;
    end
  end

  always_comb begin
    alarm_d = alarm_q;
    cnt_d   = cnt_q;
    case (alarm_q)
      StIdle: alarm_d = StArmed;
      StArmed: begin
        // Only a running-clock increment can start the ring, never a time load.
        if (inc && (inc_hour == al_hour_q) && (inc_min == al_min_q)) begin
          alarm_d = StRing;
          cnt_d   = 6'd0;
        end
      end
      StRing: begin
        if (alarm_off_i) begin
          alarm_d = StArmed;
`ifdef SNOOZE_EN
        end else if (snooze_i) begin
          alarm_d = StSnooze;
          cnt_d   = 6'd0;
`endif
        end else if (one_minute_i) begin
          cnt_d = cnt_inc[5:0];
          if (cnt_inc >= TimeoutLim) alarm_d = StArmed;
        end
      end
`ifdef SNOOZE_EN
      StSnooze: begin
        if (alarm_off_i) begin
          alarm_d = StArmed;
        end else if (one_minute_i) begin
          cnt_d = cnt_inc[5:0];
          if (cnt_inc >= SnoozeLim) begin
            alarm_d = StRing;
            cnt_d   = 6'd0;
          end
        end
      end
`endif
      default: alarm_d = StIdle;
    endcase
    if (!alarm_en_i) alarm_d = StIdle;
  end

  always_ff @(posedge clk256_i or negedge reset_ni) begin
    if (!reset_ni) begin
      time_q    <= StRun;
      alarm_q   <= StIdle;
      hour_q    <= 5'd0;
      min_q     <= 6'd0;
      al_hour_q <= 5'd0;
      al_min_q  <= 6'd0;
      cnt_q     <= 6'd0;
      err_q     <= 1'b0;
      fast_q    <= 1'b0;
      colon_q   <= 1'b0;
    end else begin
      time_q    <= time_d;
      alarm_q   <= alarm_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      fast_q    <= fast_d;
      colon_q   <= colon_d;
    end
  end

  assign set_ack_o      = (time_q == StAck);
  assign set_err_o      = err_q;
  assign fast_mode_o    = fast_q;
  assign colon_o        = colon_q;
  assign cur_hour_o     = hour_q;
  assign cur_min_o      = min_q;
  assign alarm_active_o = (alarm_q == StRing);

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Self-checking bench for alarm_clock_ctrl: directed scenarios plus randomized
// traffic against a time-of-day reference model.
module tb_alarm_clock_ctrl;
  localparam int unsigned RingTo    = 10;
  localparam int unsigned SnoozeMin = 9;
`ifdef SNOOZE_EN
  localparam bit SnoozeEn = 1'b1;
`else
  localparam bit SnoozeEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       one_second, one_minute, fast_req, set_req;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic       alarm_set, alarm_en, alarm_off, snooze;
  logic       fast_mode, set_ack, set_err, alarm_active, colon;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: time of day in minutes, handshake phase, alarm phase.
  int m_tod, m_phase, m_err, m_fast, m_colon, m_alarm, m_amode, m_cnt;

  alarm_clock_ctrl #(
    .RING_TIMEOUT_MIN(RingTo),
    .SNOOZE_MIN      (SnoozeMin)
  ) dut (
    .clk256_i      (clk),
    .reset_ni      (reset_n),
    .one_second_i  (one_second),
    .one_minute_i  (one_minute),
    .fast_req_i    (fast_req),
    .fast_mode_o   (fast_mode),
    .set_req_i     (set_req),
    .set_hour_i    (set_hour),
    .set_min_i     (set_min),
    .set_ack_o     (set_ack),
    .set_err_o     (set_err),
    .alarm_set_i   (alarm_set),
    .alarm_en_i    (alarm_en),
    .alarm_off_i   (alarm_off),
    .snooze_i      (snooze),
    .cur_hour_o    (cur_hour),
    .cur_min_o     (cur_min),
    .alarm_active_o(alarm_active),
    .colon_o       (colon)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    one_second = 0; one_minute = 0; fast_req = 0; set_req = 0;
    set_hour = 0; set_min = 0; alarm_set = 0; alarm_off = 0; snooze = 0;
  endtask

  task automatic model_reset();
    m_tod = 0; m_phase = 0; m_err = 0; m_fast = 0; m_colon = 0;
    m_alarm = 0; m_amode = 0; m_cnt = 0;
  endtask

  // phase: 0 running, 1 loading, 2 acknowledging. amode: 0 off, 1 armed, 2 ring, 3 snooze.
  task automatic tick();
    int tod_n, phase_n, amode_n, req;
    bit valid, adv;
    @(posedge clk);
    valid = (int'(set_hour) <= 23) && (int'(set_min) <= 59);
    req   = int'(set_hour) * 60 + int'(set_min);
    adv   = one_minute && (m_phase != 1);
    tod_n = adv ? (m_tod + 1) % 1440 : m_tod;
    phase_n = m_phase;
    if (m_phase == 0) begin
      if (set_req) phase_n = 1;
    end else if (m_phase == 1) begin
      if (valid) begin tod_n = req; m_err = 0; end
      else m_err = 1;
      phase_n = 2;
    end else if (!set_req) begin
      phase_n = 0;
    end
    amode_n = m_amode;
    if (m_amode == 0) begin
      amode_n = 1;
    end else if (m_amode == 1) begin
      if (adv && tod_n == m_alarm) begin amode_n = 2; m_cnt = 0; end
    end else if (m_amode == 2) begin
      if (alarm_off) amode_n = 1;
      else if (SnoozeEn && snooze) begin amode_n = 3; m_cnt = 0; end
      else if (one_minute) begin
        m_cnt++;
        if (m_cnt == RingTo) amode_n = 1;
      end
    end else begin
      if (alarm_off) amode_n = 1;
      else if (one_minute) begin
        m_cnt++;
        if (m_cnt == SnoozeMin) begin amode_n = 2; m_cnt = 0; end
      end
    end
    if (!alarm_en) amode_n = 0;
    if (alarm_set && valid) m_alarm = req;
    m_fast  = (fast_req && phase_n == 0) ? 1 : 0;
    m_colon = m_colon ^ int'(one_second);
    m_tod = tod_n; m_phase = phase_n; m_amode = amode_n;
    #1;
  endtask

  task automatic pulse_min();
    one_minute = 1; tick(); one_minute = 0;
  endtask

  task automatic do_set(input int h, input int m);
    set_hour = 5'(h); set_min = 6'(m); set_req = 1;
    tick(); tick();
    set_req = 0;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 0;
    #10;
    reset_n = 1;
    clear_inputs();
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    alarm_en = 0;
    reset_n = 0;
    #1;
    n_chk++;
    if ({cur_hour, cur_min, set_ack, set_err, fast_mode, colon, alarm_active} !== 16'd0)
      $display("FAIL reset_state: got %0d:%0d ack=%b err=%b fast=%b colon=%b act=%b want all 0",
               cur_hour, cur_min, set_ack, set_err, fast_mode, colon, alarm_active);
    else n_pass++;
    #12;
    reset_n = 1;
    model_reset();
    one_second = 1; tick(); one_second = 0;
    n_chk++;
    if (colon !== 1'b1) $display("FAIL colon_toggle: got %b want 1", colon);
    else n_pass++;
    one_second = 1; tick(); one_second = 0;
    n_chk++;
    if (colon !== 1'b0) $display("FAIL colon_toggle2: got %b want 0", colon);
    else n_pass++;
  endtask

  task automatic test_rollover();
    for (int i = 0; i < 60; i++) pulse_min();
    n_chk++;
    if (cur_hour !== 5'd1 || cur_min !== 6'd0)
      $display("FAIL rollover_hour: got %0d:%0d want 1:0", cur_hour, cur_min);
    else n_pass++;
    do_set(23, 59);
    pulse_min();
    n_chk++;
    if (cur_hour !== 5'd0 || cur_min !== 6'd0)
      $display("FAIL rollover_day: got %0d:%0d want 0:0", cur_hour, cur_min);
    else n_pass++;
  endtask

  task automatic test_set();
    set_hour = 5'd13; set_min = 6'd45; set_req = 1;
    tick();
    n_chk++;
    if (set_ack !== 1'b0) $display("FAIL set_ack_early: got %b want 0", set_ack);
    else n_pass++;
    tick();
    n_chk++;
    if (set_ack !== 1'b1 || cur_hour !== 5'd13 || cur_min !== 6'd45 || set_err !== 1'b0)
      $display("FAIL set_load: got ack=%b %0d:%0d err=%b want ack=1 13:45 err=0",
               set_ack, cur_hour, cur_min, set_err);
    else n_pass++;
    tick();
    n_chk++;
    if (set_ack !== 1'b1) $display("FAIL set_ack_hold: got %b want 1", set_ack);
    else n_pass++;
    set_req = 0;
    tick();
    n_chk++;
    if (set_ack !== 1'b0) $display("FAIL set_ack_drop: got %b want 0", set_ack);
    else n_pass++;
  endtask

  task automatic test_set_err();
    set_hour = 5'd24; set_min = 6'd10; set_req = 1;
    tick(); tick();
    n_chk++;
    if (set_err !== 1'b1 || set_ack !== 1'b1 || cur_hour !== 5'd13 || cur_min !== 6'd45)
      $display("FAIL set_invalid: got err=%b ack=%b %0d:%0d want err=1 ack=1 13:45",
               set_err, set_ack, cur_hour, cur_min);
    else n_pass++;
    set_req = 0;
    tick();
    n_chk++;
    if (set_ack !== 1'b0) $display("FAIL set_invalid_done: got ack=%b want 0", set_ack);
    else n_pass++;
  endtask

  task automatic test_fast();
    fast_req = 1; tick();
    n_chk++;
    if (fast_mode !== 1'b1) $display("FAIL fast_follow: got %b want 1", fast_mode);
    else n_pass++;
    set_hour = 5'd13; set_min = 6'd45; set_req = 1;
    tick();
    n_chk++;
    if (fast_mode !== 1'b0) $display("FAIL fast_load_mask: got %b want 0", fast_mode);
    else n_pass++;
    tick();
    set_req = 0;
    tick();
    n_chk++;
    if (fast_mode !== 1'b1) $display("FAIL fast_resume: got %b want 1", fast_mode);
    else n_pass++;
    fast_req = 0;
    tick();
  endtask

  task automatic test_alarm_timeout();
    set_hour = 5'd7; set_min = 6'd0; alarm_set = 1; alarm_en = 1;
    tick();
    alarm_set = 0;
    do_set(6, 59);
    pulse_min();
    n_chk++;
    if (alarm_active !== 1'b1) $display("FAIL alarm_ring: got %b want 1", alarm_active);
    else n_pass++;
    for (int i = 0; i < 9; i++) pulse_min();
    n_chk++;
    if (alarm_active !== 1'b1) $display("FAIL ring_before_timeout: got %b want 1", alarm_active);
    else n_pass++;
    pulse_min();
    n_chk++;
    if (alarm_active !== 1'b0) $display("FAIL ring_timeout: got %b want 0", alarm_active);
    else n_pass++;
  endtask

  task automatic test_snooze();
    do_set(6, 59);
    pulse_min();
    snooze = 1; tick(); snooze = 0;
    if (SnoozeEn) begin
      n_chk++;
      if (alarm_active !== 1'b0) $display("FAIL snooze_quiet: got %b want 0", alarm_active);
      else n_pass++;
      for (int i = 0; i < 8; i++) pulse_min();
      n_chk++;
      if (alarm_active !== 1'b0) $display("FAIL snooze_early: got %b want 0", alarm_active);
      else n_pass++;
      pulse_min();
      n_chk++;
      if (alarm_active !== 1'b1) $display("FAIL snooze_reRing: got %b want 1", alarm_active);
      else n_pass++;
      snooze = 1; alarm_off = 1; tick(); snooze = 0; alarm_off = 0;
      for (int i = 0; i < 12; i++) pulse_min();
      n_chk++;
      if (alarm_active !== 1'b0) $display("FAIL off_beats_snooze: got %b want 0", alarm_active);
      else n_pass++;
    end else begin
      n_chk++;
      if (alarm_active !== 1'b1) $display("FAIL snooze_ignored: got %b want 1", alarm_active);
      else n_pass++;
      alarm_off = 1; tick(); alarm_off = 0;
      n_chk++;
      if (alarm_active !== 1'b0) $display("FAIL alarm_off: got %b want 0", alarm_active);
      else n_pass++;
    end
  endtask

  task automatic test_reset_async();
    set_hour = 5'd10; set_min = 6'd20; set_req = 1;
    tick(); tick();
    #2;
    reset_n = 0;
    #1;
    n_chk++;
    if ({cur_hour, cur_min, set_ack, set_err, fast_mode, colon, alarm_active} !== 16'd0)
      $display("FAIL reset_in_ack: got %0d:%0d ack=%b err=%b act=%b want 0:0 all 0",
               cur_hour, cur_min, set_ack, set_err, alarm_active);
    else n_pass++;
    #10;
    reset_n = 1;
    clear_inputs();
    model_reset();
    tick(); tick();
    n_chk++;
    if (set_ack !== 1'b0 || cur_hour !== 5'd0 || cur_min !== 6'd0)
      $display("FAIL ack_abandoned: got ack=%b %0d:%0d want 0 0:0", set_ack, cur_hour, cur_min);
    else n_pass++;
    do_set(23, 59);
    pulse_min();
    n_chk++;
    if (alarm_active !== 1'b1) $display("FAIL ring_midnight: got %b want 1", alarm_active);
    else n_pass++;
    #2;
    reset_n = 0;
    #1;
    n_chk++;
    if (alarm_active !== 1'b0 || cur_hour !== 5'd0 || cur_min !== 6'd0 || colon !== 1'b0)
      $display("FAIL reset_in_ring: got act=%b %0d:%0d colon=%b want 0 0:0 0",
               alarm_active, cur_hour, cur_min, colon);
    else n_pass++;
    #10;
    reset_n = 1;
    clear_inputs();
    model_reset();
  endtask

  task automatic test_random();
    int tgt;
    for (int i = 0; i < 1500; i++) begin
      one_second = ($urandom_range(0, 9) < 3);
      one_minute = ($urandom_range(0, 9) < 4);
      fast_req   = $urandom_range(0, 1);
      alarm_en   = ($urandom_range(0, 19) != 0);
      alarm_off  = ($urandom_range(0, 29) == 0);
      snooze     = ($urandom_range(0, 19) == 0);
      if (m_phase == 0) set_req = ($urandom_range(0, 29) == 0);
      else if (m_phase == 2) set_req = ($urandom_range(0, 2) != 0);
      alarm_set = ($urandom_range(0, 39) == 0);
      if (alarm_set && $urandom_range(0, 1) == 1) begin
        tgt = (m_tod + int'($urandom_range(1, 3))) % 1440;
        set_hour = 5'(tgt / 60); set_min = 6'(tgt % 60);
      end else begin
        set_hour = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31))
                                               : 5'($urandom_range(0, 23));
        set_min  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63))
                                               : 6'($urandom_range(0, 59));
      end
      tick();
      n_chk++;
      if (cur_hour !== 5'(m_tod / 60) || cur_min !== 6'(m_tod % 60) ||
          set_ack !== (m_phase == 2) || set_err !== 1'(m_err) || fast_mode !== 1'(m_fast) ||
          colon !== 1'(m_colon) || alarm_active !== (m_amode == 2))
        $display("FAIL random_cycle%0d: got %0d:%0d ack=%b err=%b fast=%b col=%b act=%b want %0d:%0d ack=%0d err=%0d fast=%0d col=%0d act=%0d",
                 i, cur_hour, cur_min, set_ack, set_err, fast_mode, colon, alarm_active,
                 m_tod / 60, m_tod % 60, m_phase == 2, m_err, m_fast, m_colon, m_amode == 2);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rollover();
    test_set();
    test_set_err();
    test_fast();
    test_alarm_timeout();
    test_snooze();
    test_reset_async();
    alarm_en = 1;
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
